// File: rtl/voice_allocator_if.sv
// Command handshake bundle between a note-command source and voice_allocator.
// The source drives a 16-bit command word with a valid strobe and waits for
// ready; the allocator takes each command exactly once.
interface voice_allocator_if;
  logic [15:0] i_cmd;
  logic        i_cmd_valid;
  logic        o_cmd_ready;

  // Command source side.
  modport master (
    output i_cmd,
    output i_cmd_valid,
    input  o_cmd_ready
  );

  // Allocator side.
  modport slave (
    input  i_cmd,
    input  i_cmd_valid,
    output o_cmd_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: command front-end for the synthesizer voice banks.
// Takes START/STOP note commands over a valid/ready handshake, scans the
// banks one per cycle, then assigns, retriggers, steals or frees a bank.
// Optional build macro VOICE_STEAL_EN: when defined, a START that finds
// neither a matching nor a free bank takes the oldest active bank; when
// undefined, such a START is dropped and o_steal is tied low.
module voice_allocator #(
  parameter int VOICES = 8,
  parameter int AGE_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  voice_allocator_if.slave              cmd_if,
  output logic [VOICES-1:0]             o_voice_on,
  output logic [VOICES*7-1:0]           o_voice_note,
  output logic [VOICES*8-1:0]           o_voice_vel,
  output logic [VOICES-1:0]             o_load,
  output logic                          o_steal,
  output logic [$clog2(VOICES+1)-1:0]   o_active_cnt
);

  localparam int IDX_W = $clog2(VOICES);
  localparam int CNT_W = $clog2(VOICES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Saturating age increment: an old voice stays old, it never wraps young.
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
    logic [AGE_W-1:0] res;
    if (age == AGE_MAX) begin
      res = age;
    end else begin
      res = age + AGE_W'(1);
    end
    return res;
  endfunction

  // Control state
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             ready_q, ready_d;

  // Per-bank state
  logic [VOICES-1:0]            gate_q, gate_d;
  logic [VOICES-1:0][6:0]       note_q, note_d;
  logic [VOICES-1:0][7:0]       vel_q, vel_d;
  logic [VOICES-1:0][AGE_W-1:0] age_q, age_d;
  logic [VOICES-1:0]            load_q, load_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  // Scan results
  logic             match_hit_q, match_hit_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d;
  logic             free_hit_q, free_hit_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
`ifdef VOICE_STEAL_EN
  logic             old_hit_q, old_hit_d;
  logic [IDX_W-1:0] old_idx_q, old_idx_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;
  logic             steal_q, steal_d;
`endif

  // Decoded fields of the latched command and commit helpers
  logic             accept_s;
  logic             cmd_start_s;
  logic [6:0]       cmd_note_s;
  logic [7:0]       cmd_vel_s;
  logic [IDX_W-1:0] tgt_s;
  logic             apply_s;

  // Next-state logic: handshake, bank scan and the commit update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    ready_d     = ready_q;
    gate_d      = gate_q;
    note_d      = note_q;
    vel_d       = vel_q;
    age_d       = age_q;
    load_d      = '0;
    match_hit_d = match_hit_q;
    match_idx_d = match_idx_q;
    free_hit_d  = free_hit_q;
    free_idx_d  = free_idx_q;
`ifdef VOICE_STEAL_EN
    old_hit_d   = old_hit_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    steal_d     = 1'b0;
`endif
    accept_s    = cmd_if.i_cmd_valid & ready_q;
    cmd_start_s = cmd_q[15];
    cmd_note_s  = cmd_q[14:8];
    cmd_vel_s   = cmd_q[7:0];
    tgt_s       = '0;
    apply_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (cmd_if.i_cmd[14:8] == 7'd0) begin
            // Note 0: STOP means stop-all right now, START is meaningless.
            if (!cmd_if.i_cmd[15]) begin
              gate_d = '0;
              age_d  = '0;
            end else begin
              gate_d = gate_q;
            end
          end else begin
            cmd_d       = cmd_if.i_cmd;
            state_d     = ST_SCAN;
            idx_d       = '0;
            ready_d     = 1'b0;
            match_hit_d = 1'b0;
            match_idx_d = '0;
            free_hit_d  = 1'b0;
            free_idx_d  = '0;
`ifdef VOICE_STEAL_EN
            old_hit_d   = 1'b0;
            old_idx_d   = '0;
            old_age_d   = '0;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (gate_q[idx_q] && (note_q[idx_q] == cmd_note_s)) begin
          match_hit_d = 1'b1;
          match_idx_d = idx_q;
        end else begin
          match_hit_d = match_hit_q;
        end
        // First free bank wins, so later free banks are ignored.
        if (!gate_q[idx_q] && !free_hit_q) begin
          free_hit_d = 1'b1;
          free_idx_d = idx_q;
        end else begin
          free_hit_d = free_hit_q;
        end
`ifdef VOICE_STEAL_EN
        // Strictly greater keeps the lowest index on an age tie.
        if (gate_q[idx_q] && (!old_hit_q || (age_q[idx_q] > old_age_q))) begin
          old_hit_d = 1'b1;
          old_idx_d = idx_q;
          old_age_d = age_q[idx_q];
        end else begin
          old_hit_d = old_hit_q;
        end
`endif
        if (idx_q == LAST_IDX) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        if (cmd_start_s) begin
          if (match_hit_q) begin
            tgt_s   = match_idx_q;
            apply_s = 1'b1;
          end else if (free_hit_q) begin
            tgt_s   = free_idx_q;
            apply_s = 1'b1;
          end else begin
`ifdef VOICE_STEAL_EN
            if (old_hit_q) begin
              tgt_s   = old_idx_q;
              apply_s = 1'b1;
              steal_d = 1'b1;
            end else begin
              apply_s = 1'b0;
            end
`else
            apply_s = 1'b0;
`endif
          end
          if (apply_s) begin
            for (int i = 0; i < VOICES; i++) begin
              if (gate_q[i] && (IDX_W'(i) != tgt_s)) begin
                age_d[i] = age_inc(age_q[i]);
              end else begin
                age_d[i] = age_q[i];
              end
            end
            gate_d[tgt_s] = 1'b1;
            note_d[tgt_s] = cmd_note_s;
            vel_d[tgt_s]  = cmd_vel_s;
            age_d[tgt_s]  = '0;
            load_d[tgt_s] = 1'b1;
          end else begin
            load_d = '0;
          end
        end else begin
          // STOP releases the gate but keeps note/velocity for the release tail.
          if (match_hit_q) begin
            gate_d[match_idx_q] = 1'b0;
            age_d[match_idx_q]  = '0;
          end else begin
            gate_d = gate_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Active-bank count follows the next gate vector so it registers with it.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < VOICES; i++) begin
      cnt_d = cnt_d + CNT_W'(gate_d[i]);
    end
  end

  // State registers; reset aborts any pending command and clears all banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cmd_q       <= 16'h0000;
      ready_q     <= 1'b1;
      gate_q      <= '0;
      note_q      <= '0;
      vel_q       <= '0;
      age_q       <= '0;
      load_q      <= '0;
      cnt_q       <= '0;
      match_hit_q <= 1'b0;
      match_idx_q <= '0;
      free_hit_q  <= 1'b0;
      free_idx_q  <= '0;
`ifdef VOICE_STEAL_EN
      old_hit_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      steal_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      ready_q     <= ready_d;
      gate_q      <= gate_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      age_q       <= age_d;
      load_q      <= load_d;
      cnt_q       <= cnt_d;
      match_hit_q <= match_hit_d;
      match_idx_q <= match_idx_d;
      free_hit_q  <= free_hit_d;
      free_idx_q  <= free_idx_d;
`ifdef VOICE_STEAL_EN
      old_hit_q   <= old_hit_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      steal_q     <= steal_d;
`endif
    end
  end

  assign cmd_if.o_cmd_ready = ready_q;
  assign o_voice_on         = gate_q;
  assign o_voice_note       = note_q;
  assign o_voice_vel        = vel_q;
  assign o_load             = load_q;
  assign o_active_cnt       = cnt_q;
`ifdef VOICE_STEAL_EN
  assign o_steal            = steal_q;
`else
  assign o_steal            = 1'b0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed vector table, hand-written
// multi-cycle sequences, and random commands against a behavioural model.
module tb_voice_allocator;
  localparam int VOICES  = 8;
  localparam int AGE_W   = 4;
  localparam int AGE_TOP = (1 << AGE_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [VOICES-1:0]    voice_on;
  logic [VOICES*7-1:0]  voice_note;
  logic [VOICES*8-1:0]  voice_vel;
  logic [VOICES-1:0]    load;
  logic                 steal;
  logic [3:0]           active_cnt;

  voice_allocator_if cmd_if ();

  voice_allocator #(.VOICES(VOICES), .AGE_W(AGE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_if       (cmd_if),
    .o_voice_on   (voice_on),
    .o_voice_note (voice_note),
    .o_voice_vel  (voice_vel),
    .o_load       (load),
    .o_steal      (steal),
    .o_active_cnt (active_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model of the bank array
  bit m_on   [VOICES];
  int m_note [VOICES];
  int m_vel  [VOICES];
  int m_age  [VOICES];

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  on;
    logic [3:0]  cnt;
    logic [7:0]  ld;
    logic        st;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_on[i] = 1'b0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
  endfunction

  // Applies one accepted command to the model; imm marks single-cycle commands.
  function automatic void model_apply(input logic [15:0] c, output bit imm,
                                      output logic [VOICES-1:0] eload, output bit esteal);
    int note, k;
    bit start;
    note = int'(c[14:8]);
    start = c[15];
    eload = '0; esteal = 1'b0; imm = 1'b0;
    if (note == 0) begin
      imm = 1'b1;
      if (!start) for (int i = 0; i < VOICES; i++) begin m_on[i] = 1'b0; m_age[i] = 0; end
      return;
    end
    k = -1;
    for (int i = 0; i < VOICES; i++) if (m_on[i] && m_note[i] == note) k = i;
    if (!start) begin
      if (k >= 0) begin m_on[k] = 1'b0; m_age[k] = 0; end
      return;
    end
    if (k < 0) for (int i = VOICES - 1; i >= 0; i--) if (!m_on[i]) k = i;
    if (k < 0) begin
`ifdef VOICE_STEAL_EN
      for (int i = 0; i < VOICES; i++)
        if (m_on[i] && (k < 0 || m_age[i] > m_age[k])) k = i;
      esteal = 1'b1;
`else
      return;
`endif
    end
    for (int i = 0; i < VOICES; i++)
      if (m_on[i] && i != k) m_age[i] = (m_age[i] < AGE_TOP) ? m_age[i] + 1 : AGE_TOP;
    m_on[k] = 1'b1; m_note[k] = note; m_vel[k] = int'(c[7:0]); m_age[k] = 0;
    eload[k] = 1'b1;
  endfunction

  task automatic check_state(input string tag);
    logic [VOICES-1:0]   eon;
    logic [VOICES*7-1:0] en;
    logic [VOICES*8-1:0] ev;
    int c;
    c = 0;
    for (int i = 0; i < VOICES; i++) begin
      eon[i] = m_on[i];
      en[i*7 +: 7] = 7'(m_note[i]);
      ev[i*8 +: 8] = 8'(m_vel[i]);
      c += int'(m_on[i]);
    end
    chk({tag, ".on"},   64'(voice_on),   64'(eon));
    chk({tag, ".note"}, 64'(voice_note), 64'(en));
    chk({tag, ".vel"},  64'(voice_vel),  64'(ev));
    chk({tag, ".cnt"},  64'(active_cnt), 64'(c));
  endtask

  // Sends one command, waits the full latency and checks against the model.
  task automatic do_cmd(input logic [15:0] c, output logic [VOICES-1:0] got_load,
                        output logic got_steal);
    int w;
    bit imm, esteal, busy_bad;
    logic [VOICES-1:0] eload;
    cmd_if.i_cmd = c;
    cmd_if.i_cmd_valid = 1'b1;
    w = 0;
    while (cmd_if.o_cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) begin
      n_total++;
      $display("FAIL ready_wait: ready stayed %b, expected 1", cmd_if.o_cmd_ready);
      cmd_if.i_cmd_valid = 1'b0;
      got_load = '0; got_steal = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_if.i_cmd_valid = 1'b0;
    model_apply(c, imm, eload, esteal);
    if (imm) begin
      chk("imm.ready", 64'(cmd_if.o_cmd_ready), 64'd1);
    end else begin
      busy_bad = 1'b0;
      for (int k = 0; k <= VOICES; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        if (cmd_if.o_cmd_ready !== 1'b0 || load !== '0) busy_bad = 1'b1;
      end
      chk("busy", 64'(busy_bad), 64'd0);
      @(posedge clk); #1;
      chk("done.ready", 64'(cmd_if.o_cmd_ready), 64'd1);
    end
    got_load = load;
    got_steal = steal;
    chk("load", 64'(load), 64'(eload));
    chk("steal", 64'(steal), 64'(esteal));
    check_state("state");
    @(posedge clk); #1;
    chk("pulse_clear", 64'({load, steal}), 64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cmd_if.i_cmd_valid = 1'b0;
    cmd_if.i_cmd = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset.ready", 64'(cmd_if.o_cmd_ready), 64'd1);
    chk("reset.pulses", 64'({load, steal}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [VOICES-1:0] gl;
    logic gs, dummy_imm_l;
    bit dimm, dst;
    logic [VOICES-1:0] dld;
    int acc [5];
    int w;
    logic [15:0] c;

    tbl[0]  = '{16'hC500, 8'h01, 4'd1, 8'h01, 1'b0};
    tbl[1]  = '{16'h4A00, 8'h01, 4'd1, 8'h00, 1'b0};
    tbl[2]  = '{16'h450F, 8'h00, 4'd0, 8'h00, 1'b0};
    tbl[3]  = '{16'hC500, 8'h01, 4'd1, 8'h01, 1'b0};
    tbl[4]  = '{16'hC500, 8'h01, 4'd1, 8'h01, 1'b0};
    tbl[5]  = '{16'hC640, 8'h03, 4'd2, 8'h02, 1'b0};
    tbl[6]  = '{16'hC750, 8'h07, 4'd3, 8'h04, 1'b0};
    tbl[7]  = '{16'hC860, 8'h0F, 4'd4, 8'h08, 1'b0};
    tbl[8]  = '{16'hC970, 8'h1F, 4'd5, 8'h10, 1'b0};
    tbl[9]  = '{16'hCA10, 8'h3F, 4'd6, 8'h20, 1'b0};
    tbl[10] = '{16'hCB20, 8'h7F, 4'd7, 8'h40, 1'b0};
    tbl[11] = '{16'hCC30, 8'hFF, 4'd8, 8'h80, 1'b0};
`ifdef VOICE_STEAL_EN
    tbl[12] = '{16'hCD40, 8'hFF, 4'd8, 8'h01, 1'b1};
`else
    tbl[12] = '{16'hCD40, 8'hFF, 4'd8, 8'h00, 1'b0};
`endif
    tbl[13] = '{16'h4600, 8'hFD, 4'd7, 8'h00, 1'b0};
    tbl[14] = '{16'h4700, 8'hF9, 4'd6, 8'h00, 1'b0};
    tbl[15] = '{16'h8055, 8'hF9, 4'd6, 8'h00, 1'b0};
    tbl[16] = '{16'h0033, 8'h00, 4'd0, 8'h00, 1'b0};

    apply_reset();

    // Directed table
    for (int i = 0; i < 17; i++) begin
      do_cmd(tbl[i].cmd, gl, gs);
      chk($sformatf("tbl%0d.on", i),    64'(voice_on),   64'(tbl[i].on));
      chk($sformatf("tbl%0d.cnt", i),   64'(active_cnt), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d.load", i),  64'(gl),         64'(tbl[i].ld));
      chk($sformatf("tbl%0d.steal", i), 64'(gs),         64'(tbl[i].st));
    end

    // Five STARTs with valid held high: one accept per VOICES+2 cycles
    apply_reset();
    cmd_if.i_cmd_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      c = {1'b1, 7'(60 + j), 8'(16 * j + 1)};
      cmd_if.i_cmd = c;
      w = 0;
      while (cmd_if.o_cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
      @(posedge clk); #1;
      acc[j] = cyc;
      model_apply(c, dimm, dld, dst);
      chk($sformatf("b2b%0d.ready_low", j), 64'(cmd_if.o_cmd_ready), 64'd0);
      if (j > 0) chk($sformatf("b2b%0d.gap", j), 64'(acc[j] - acc[j-1]), 64'(VOICES + 2));
    end
    cmd_if.i_cmd_valid = 1'b0;
    repeat (VOICES + 1) @(posedge clk);
    #1;
    check_state("b2b");
    chk("b2b.on", 64'(voice_on), 64'h1F);
    chk("b2b.cnt", 64'(active_cnt), 64'd5);

    // Reset in the middle of a scan aborts the command
    cmd_if.i_cmd = 16'hC863;
    cmd_if.i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_if.i_cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("midscan_rst");
    chk("midscan_rst.ready", 64'(cmd_if.o_cmd_ready), 64'd1);
    chk("midscan_rst.pulses", 64'({load, steal}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_cmd(16'hC500, gl, gs);
    chk("post_rst.load", 64'(gl), 64'h01);

    // Random commands against the model
    for (int n = 0; n < 120; n++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0)      c = {1'b0, 7'd0, 8'($urandom)};
      else if (r == 1) c = {1'b1, 7'd0, 8'($urandom)};
      else if (r < 5)  c = {1'b0, 7'($urandom_range(60, 71)), 8'($urandom)};
      else             c = {1'b1, 7'($urandom_range(60, 71)), 8'($urandom)};
      do_cmd(c, gl, gs);
    end

    dummy_imm_l = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
